// File: rtl/ws2812_frame_driver_if.sv
// rtl/ws2812_frame_driver_if.sv - per-LED colour request/return bus between compositor and strip driver
interface ws2812_frame_driver_if #(
    parameter int MAX_POS = 109
);
    localparam int IDX_W = (MAX_POS > 1) ? $clog2(MAX_POS) : 1;

    logic [IDX_W-1:0] current_led;
    logic [7:0]       green;
    logic [7:0]       red;
    logic [7:0]       blue;

    // master is the strip driver asking for a colour, slave is the compositor answering
    modport master (output current_led, input green, red, blue);
    modport slave  (input current_led, output green, red, blue);
endinterface

// File: rtl/ws2812_frame_driver.sv
// rtl/ws2812_frame_driver.sv - scans LED indices and serialises GRB colours onto a WS2812 one-wire line
module ws2812_frame_driver #(
    parameter int MAX_POS      = 109,
    parameter int BIT_CYCLES   = 62,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int RESET_CYCLES = 3000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    ws2812_frame_driver_if.master  led_bus,
    output logic                   data_out,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int IDX_W   = (MAX_POS > 1) ? $clog2(MAX_POS) : 1;
    localparam int CYC_MAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    localparam logic [CYC_W-1:0] BIT_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] GAP_LAST = CYC_W'(RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H_CYCLES);
    localparam logic [IDX_W-1:0] LED_LAST = IDX_W'(MAX_POS - 1);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES && RESET_CYCLES > 0))
    begin : g_bad_timing
        $error("ws2812_frame_driver: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES and RESET_CYCLES > 0");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t           state, state_d;
    logic [23:0]      sr, sr_d;
    logic [4:0]       bit_idx, bit_idx_d;
    logic [CYC_W-1:0] cyc, cyc_d;
    logic [IDX_W-1:0] led, led_d;
    logic             last_led, last_led_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            bit_idx  <= '0;
            cyc      <= '0;
            led      <= '0;
            last_led <= 1'b0;
        end else begin
            state    <= state_d;
            sr       <= sr_d;
            bit_idx  <= bit_idx_d;
            cyc      <= cyc_d;
            led      <= led_d;
            last_led <= last_led_d;
        end
    end

    always_comb begin
        state_d    = state;
        sr_d       = sr;
        bit_idx_d  = bit_idx;
        cyc_d      = cyc;
        led_d      = led;
        last_led_d = last_led;
        data_out   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                led_d = '0;
                cyc_d = '0;
                if (enable) state_d = LOAD;
            end
            LOAD: begin
                sr_d       = {led_bus.green, led_bus.red, led_bus.blue};
                bit_idx_d  = '0;
                cyc_d      = '0;
                last_led_d = (led == LED_LAST);
                state_d    = SEND;
            end
            SEND: begin
                data_out = (cyc < (sr[23] ? T1H_C : T0H_C));
                // Advancing the index early gives upstream the rest of bit 23 to settle its colour
                if (bit_idx == 5'd23 && cyc == '0 && led < LED_LAST)
                    led_d = led + IDX_W'(1);
                if (cyc == BIT_LAST) begin
                    cyc_d = '0;
                    if (bit_idx == 5'd23) begin
                        if (last_led) begin
                            led_d   = '0;
                            state_d = GAP;
                        end else begin
                            // led already points at the next LED here
                            sr_d       = {led_bus.green, led_bus.red, led_bus.blue};
                            bit_idx_d  = '0;
                            last_led_d = (led == LED_LAST);
                        end
                    end else begin
                        sr_d      = {sr[22:0], 1'b0};
                        bit_idx_d = bit_idx + 5'd1;
                    end
                end else begin
                    cyc_d = cyc + CYC_W'(1);
                end
            end
            GAP: begin
                if (cyc == GAP_LAST) begin
                    frame_done = 1'b1;
                    cyc_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cyc_d = cyc + CYC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy                = (state != IDLE);
    assign led_bus.current_led = led;
endmodule

// File: tb/tb_ws2812_frame_driver.sv
// tb/tb_ws2812_frame_driver.sv - directed self-checking bench for ws2812_frame_driver
module tb_ws2812_frame_driver;
    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic data_out;
    logic busy;
    logic frame_done;
    bit   per_led;
    int   passed = 0;
    int   fails  = 0;
    int   total  = 0;
    int   cyc_cnt = 0;
    int   t0;
    logic [7:0] col;

    ws2812_frame_driver_if #(.MAX_POS(3)) bus ();

    ws2812_frame_driver #(
        .MAX_POS(3), .BIT_CYCLES(10), .T0H_CYCLES(3), .T1H_CYCLES(7), .RESET_CYCLES(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .led_bus    (bus),
        .data_out   (data_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always_comb begin
        col = 8'h11 * (8'(bus.current_led) + 8'd1);
        if (per_led) begin
            bus.green = col;
            bus.red   = col;
            bus.blue  = col;
        end else begin
            bus.green = 8'hA5;
            bus.red   = 8'h0F;
            bus.blue  = 8'hF0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_rise(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (data_out !== 1'b1 && n < 20);
        total++;
        if (data_out !== 1'b1) begin
            fails++;
            $error("FAIL %s: observed %0h expected 1", tag, data_out);
        end else passed++;
    endtask

    task automatic run_frame(input logic [23:0] w0, input logic [23:0] w1,
                             input logic [23:0] w2, input bit drop);
        logic [23:0] words [3];
        logic [23:0] got;
        logic [9:0]  pat;
        logic [9:0]  exp_pat;
        logic [1:0]  exp_led;
        bit          led_ok;
        bit          side_ok;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        for (int k = 0; k < 3; k++) begin
            got     = '0;
            side_ok = 1'b1;
            for (int bi = 0; bi < 24; bi++) begin
                pat    = '0;
                led_ok = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    if (k != 0 || bi != 0 || c != 0) @(negedge clk);
                    pat[c]  = data_out;
                    exp_led = (bi == 23 && c >= 1 && k < 2) ? 2'(k + 1) : 2'(k);
                    if (bus.current_led !== exp_led) led_ok = 1'b0;
                    if (busy !== 1'b1 || frame_done !== 1'b0) side_ok = 1'b0;
                    if (drop && k == 1 && bi == 0 && c == 0) enable = 1'b0;
                end
                exp_pat = words[k][23-bi] ? 10'h07F : 10'h007;
                total++;
                if (pat !== exp_pat) begin
                    fails++;
                    $error("FAIL bit_shape: observed %0h expected %0h", pat, exp_pat);
                end else passed++;
                total++;
                if (led_ok !== 1'b1) begin
                    fails++;
                    $error("FAIL led_index: observed %0h expected 1", led_ok);
                end else passed++;
                got = {got[22:0], ($countones(pat) > 5)};
            end
            total++;
            if (got !== words[k]) begin
                fails++;
                $error("FAIL led_word: observed %0h expected %0h", got, words[k]);
            end else passed++;
            total++;
            if (side_ok !== 1'b1) begin
                fails++;
                $error("FAIL send_flags: observed %0h expected 1", side_ok);
            end else passed++;
        end
    endtask

    task automatic check_gap();
        logic [19:0] fd;
        bit          ok;
        fd = '0;
        ok = 1'b1;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            fd[g] = frame_done;
            if (data_out !== 1'b0 || busy !== 1'b1 || bus.current_led !== 2'd0) ok = 1'b0;
        end
        total++;
        if (ok !== 1'b1) begin
            fails++;
            $error("FAIL gap_lines: observed %0h expected 1", ok);
        end else passed++;
        total++;
        if (fd !== 20'h80000) begin
            fails++;
            $error("FAIL gap_frame_done: observed %0h expected 80000", fd);
        end else passed++;
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        per_led = 1'b0;

        repeat (3) begin
            @(negedge clk);
            total++;
            if ({data_out, busy, frame_done, bus.current_led} !== 5'b0) begin
                fails++;
                $error("FAIL rst_outputs: observed %0h expected 0", {data_out, busy, frame_done, bus.current_led});
            end else passed++;
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (data_out !== 1'b0) begin
            fails++;
            $error("FAIL load_data: observed %0h expected 0", data_out);
        end else passed++;
        total++;
        if (busy !== 1'b1) begin
            fails++;
            $error("FAIL load_busy: observed %0h expected 1", busy);
        end else passed++;
        @(negedge clk);
        total++;
        if (data_out !== 1'b1) begin
            fails++;
            $error("FAIL first_rise: observed %0h expected 1", data_out);
        end else passed++;
        enable = 1'b0;

        run_frame(24'hA50FF0, 24'hA50FF0, 24'hA50FF0, 1'b0);
        check_gap();
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({data_out, busy, frame_done} !== 3'b000) begin
                fails++;
                $error("FAIL idle_after_frame: observed %0h expected 0", {data_out, busy, frame_done});
            end else passed++;
        end

        per_led = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_rise("per_led_start");
        run_frame(24'h111111, 24'h222222, 24'h333333, 1'b0);
        check_gap();

        per_led = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_rise("drop_start");
        run_frame(24'hA50FF0, 24'hA50FF0, 24'hA50FF0, 1'b1);
        check_gap();
        repeat (5) begin
            @(negedge clk);
            total++;
            if ({data_out, busy, frame_done} !== 3'b000) begin
                fails++;
                $error("FAIL drop_idle: observed %0h expected 0", {data_out, busy, frame_done});
            end else passed++;
        end

        enable = 1'b1;
        wait_rise("b2b_start");
        t0 = cyc_cnt;
        run_frame(24'hA50FF0, 24'hA50FF0, 24'hA50FF0, 1'b0);
        check_gap();
        @(negedge clk);
        total++;
        if ({data_out, busy} !== 2'b00) begin
            fails++;
            $error("FAIL b2b_idle: observed %0h expected 0", {data_out, busy});
        end else passed++;
        @(negedge clk);
        total++;
        if ({data_out, busy} !== 2'b01) begin
            fails++;
            $error("FAIL b2b_load: observed %0h expected 1", {data_out, busy});
        end else passed++;
        @(negedge clk);
        total++;
        if (data_out !== 1'b1) begin
            fails++;
            $error("FAIL b2b_rise: observed %0h expected 1", data_out);
        end else passed++;
        total++;
        if (cyc_cnt - t0 !== 742) begin
            fails++;
            $error("FAIL b2b_period: observed %0d expected 742", cyc_cnt - t0);
        end else passed++;
        run_frame(24'hA50FF0, 24'hA50FF0, 24'hA50FF0, 1'b1);
        check_gap();
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            fails++;
            $error("FAIL b2b_end_idle: observed %0h expected 0", busy);
        end else passed++;

        @(negedge clk);
        enable = 1'b1;
        wait_rise("mid_rst_start");
        enable = 1'b0;
        repeat (294) @(negedge clk);
        total++;
        if (data_out !== 1'b1) begin
            fails++;
            $error("FAIL mid_rst_pre_data: observed %0h expected 1", data_out);
        end else passed++;
        total++;
        if (bus.current_led !== 2'd1) begin
            fails++;
            $error("FAIL mid_rst_pre_led: observed %0h expected 1", bus.current_led);
        end else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({data_out, busy, frame_done, bus.current_led} !== 5'b0) begin
            fails++;
            $error("FAIL mid_rst_after: observed %0h expected 0", {data_out, busy, frame_done, bus.current_led});
        end else passed++;
        @(negedge clk);
        total++;
        if ({data_out, busy, frame_done} !== 3'b000) begin
            fails++;
            $error("FAIL mid_rst_hold: observed %0h expected 0", {data_out, busy, frame_done});
        end else passed++;
        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        total++;
        if ({data_out, busy} !== 2'b01) begin
            fails++;
            $error("FAIL mid_rst_load: observed %0h expected 1", {data_out, busy});
        end else passed++;
        @(negedge clk);
        total++;
        if (data_out !== 1'b1) begin
            fails++;
            $error("FAIL mid_rst_rise: observed %0h expected 1", data_out);
        end else passed++;
        enable = 1'b0;
        run_frame(24'hA50FF0, 24'hA50FF0, 24'hA50FF0, 1'b0);
        check_gap();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
